// File: rtl/ram_arbiter.sv
// Three-port arbiter for a single RAM controller port: port 0 has fixed priority, ports 1/2 round-robin,
// bursts are capped while others wait, and read data is routed back by a latency-matched tag pipeline.
module ram_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          req,
    input  logic [2:0]          wen,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_wen,
    output logic                ram_ren,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state, state_next;
    logic [1:0]        owner, owner_next;
    logic [2:0]        gnt_next;
    logic [CNT_W-1:0]  count, count_next;
    logic              ptr, ptr_next;   // 0: port 1 wins a 1/2 tie, 1: port 2 wins
    logic              xfer, other;
    logic              sel_req, sel_wen;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [RD_LAT:0]   pipe_v;
    logic [1:0]        pipe_tag [RD_LAT+1];

    always_comb begin
        sel_req   = req[0];
        sel_wen   = wen[0];
        sel_addr  = addr[0 +: ADDR_W];
        sel_wdata = wdata[0 +: DATA_W];
        case (owner)
            2'd1: begin
                sel_req   = req[1];
                sel_wen   = wen[1];
                sel_addr  = addr[ADDR_W +: ADDR_W];
                sel_wdata = wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                sel_req   = req[2];
                sel_wen   = wen[2];
                sel_addr  = addr[2*ADDR_W +: ADDR_W];
                sel_wdata = wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    assign xfer  = (state == OWN) && sel_req;
    assign other = |(req & ~gnt);

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        owner_next = owner;
        count_next = count;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                gnt_next = '0;
                if (|req) begin
                    state_next = OWN;
                    count_next = '0;
                    if (req[0]) begin
                        owner_next = 2'd0;
                    end else if (req[1] && (!req[2] || !ptr)) begin
                        owner_next = 2'd1;
                        ptr_next   = 1'b1;
                    end else begin
                        owner_next = 2'd2;
                        ptr_next   = 1'b0;
                    end
                    gnt_next = 3'b001 << owner_next;
                end
            end
            OWN: begin
                if (!xfer) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                end else if (count == CNT_MAX) begin
                    // saturated count only ends the burst when someone else is waiting
                    if (other) begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            count <= '0;
            ptr   <= 1'b0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            owner <= owner_next;
            count <= count_next;
            ptr   <= ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wen   <= 1'b0;
            ram_ren   <= 1'b0;
        end else begin
            ram_wen <= xfer & sel_wen;
            ram_ren <= xfer & ~sel_wen;
            if (xfer) begin
                ram_addr  <= sel_addr;
                ram_wdata <= sel_wdata;
            end
        end
    end

    // stage 0 lines up with ram_ren; stage RD_LAT lines up with ram_rdata
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i <= RD_LAT; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_v      <= {pipe_v[RD_LAT-1:0], xfer & ~sel_wen};
            pipe_tag[0] <= owner;
            for (int unsigned i = 1; i <= RD_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    assign rvalid = pipe_v[RD_LAT] ? (3'b001 << pipe_tag[RD_LAT]) : 3'b000;
    assign rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (MAX_BURST=4, RD_LAT=2): a per-cycle vector table for
// arbitration and routing, plus hand-written sequences for bursts, read latency and reset.
module tb_ram_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req, wen;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]    gnt, rvalid;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_wen, ram_ren;
    logic [DW-1:0] d0, d1;

    int errors = 0;
    int checks = 0;

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM controller model: data = addr*3, valid RD_LAT cycles after the ram_ren cycle
    always @(posedge clk) begin
        d0 <= ram_ren ? DW'(ram_addr * 3) : 16'hdead;
        d1 <= d0;
    end
    assign ram_rdata = d1;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  wen;
        logic [18:0] a;
        logic [2:0]  gnt;
        logic        rw;
        logic        rr;
        logic [18:0] ra;
        logic [2:0]  rv;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_addr(input logic [18:0] a);
        addr  = {AW'(a + 19'd2000), AW'(a + 19'd1000), a};
        wdata = {DW'(a + 19'd200), DW'(a + 19'd100), DW'(a)};
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, ".gnt"}, 32'(gnt), 0);
        chk({nm, ".ram_wen"}, 32'(ram_wen), 0);
        chk({nm, ".ram_ren"}, 32'(ram_ren), 0);
        chk({nm, ".rvalid"}, 32'(rvalid), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req   = 3'b111;
        wen   = 3'b000;
        set_addr(19'd0);

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_zero("reset");
        end
        chk("reset.ram_addr", 32'(ram_addr), 0);
        chk("reset.ram_wdata", 32'(ram_wdata), 0);
        rst_n = 1'b1;
        req   = 3'b000;
        tick();
        chk("post_reset.gnt", 32'(gnt), 0);

        // row k inputs are applied for one cycle; outputs checked after the following edge
        tbl[0]  = '{3'b110, 3'b110, 19'd10, 3'b010, 1'b0, 1'b0, 19'd0,    3'b000, 16'd0};
        tbl[1]  = '{3'b110, 3'b110, 19'd10, 3'b010, 1'b1, 1'b0, 19'd1010, 3'b000, 16'd0};
        tbl[2]  = '{3'b100, 3'b110, 19'd10, 3'b000, 1'b0, 1'b0, 19'd1010, 3'b000, 16'd0};
        tbl[3]  = '{3'b111, 3'b111, 19'd20, 3'b001, 1'b0, 1'b0, 19'd1010, 3'b000, 16'd0};
        tbl[4]  = '{3'b111, 3'b111, 19'd20, 3'b001, 1'b1, 1'b0, 19'd20,   3'b000, 16'd0};
        tbl[5]  = '{3'b110, 3'b111, 19'd20, 3'b000, 1'b0, 1'b0, 19'd20,   3'b000, 16'd0};
        tbl[6]  = '{3'b110, 3'b000, 19'd30, 3'b100, 1'b0, 1'b0, 19'd20,   3'b000, 16'd0};
        tbl[7]  = '{3'b110, 3'b000, 19'd30, 3'b100, 1'b0, 1'b1, 19'd2030, 3'b000, 16'd0};
        tbl[8]  = '{3'b010, 3'b000, 19'd40, 3'b000, 1'b0, 1'b0, 19'd2030, 3'b000, 16'd0};
        tbl[9]  = '{3'b010, 3'b000, 19'd40, 3'b010, 1'b0, 1'b0, 19'd2030, 3'b100, 16'd6090};
        tbl[10] = '{3'b000, 3'b000, 19'd40, 3'b000, 1'b0, 1'b0, 19'd2030, 3'b000, 16'd0};
        tbl[11] = '{3'b000, 3'b000, 19'd40, 3'b000, 1'b0, 1'b0, 19'd2030, 3'b000, 16'd0};

        for (int k = 0; k < 12; k++) begin
            req = tbl[k].req;
            wen = tbl[k].wen;
            set_addr(tbl[k].a);
            tick();
            chk($sformatf("vec%0d.gnt", k), 32'(gnt), 32'(tbl[k].gnt));
            chk($sformatf("vec%0d.ram_wen", k), 32'(ram_wen), 32'(tbl[k].rw));
            chk($sformatf("vec%0d.ram_ren", k), 32'(ram_ren), 32'(tbl[k].rr));
            chk($sformatf("vec%0d.ram_addr", k), 32'(ram_addr), 32'(tbl[k].ra));
            chk($sformatf("vec%0d.rvalid", k), 32'(rvalid), 32'(tbl[k].rv));
            if (tbl[k].rv != 3'b000)
                chk($sformatf("vec%0d.rdata", k), 32'(rdata), 32'(tbl[k].rd));
        end

        // single writer on port 1, ten consecutive addresses (count saturates, no competitor)
        req = 3'b010;
        wen = 3'b010;
        addr = '0;
        wdata = '0;
        addr[AW +: AW] = AW'(0);
        wdata[DW +: DW] = DW'(100);
        tick();
        chk("single.gnt_first", 32'(gnt), 32'(3'b010));
        chk("single.wen_first", 32'(ram_wen), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("single%0d.ram_wen", i), 32'(ram_wen), 1);
            chk($sformatf("single%0d.ram_addr", i), 32'(ram_addr), 32'(i));
            chk($sformatf("single%0d.ram_wdata", i), 32'(ram_wdata), 32'(i + 100));
            chk($sformatf("single%0d.gnt", i), 32'(gnt), 32'(3'b010));
            if (i == 9) begin
                req = 3'b000;
            end else begin
                addr[AW +: AW]  = AW'(i + 1);
                wdata[DW +: DW] = DW'(i + 101);
            end
        end
        tick();
        chk("single.end_wen", 32'(ram_wen), 0);
        chk("single.end_gnt", 32'(gnt), 0);

        // burst cap: port 1 owns, port 2 waits -> 4 transfers, one bubble, then port 2
        req = 3'b010;
        wen = 3'b110;
        tick();
        chk("burst.gnt_first", 32'(gnt), 32'(3'b010));
        req = 3'b110;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt == 3'b010) n++;
            else break;
        end
        chk("burst.transfers", 32'(n), 4);
        chk("burst.bubble_gnt", 32'(gnt), 0);
        tick();
        chk("burst.next_owner", 32'(gnt), 32'(3'b100));
        req = 3'b000;
        tick();
        tick();
        chk("burst.release", 32'(gnt), 0);

        // back-to-back reads on port 2: rvalid three cycles after each transfer cycle
        req = 3'b100;
        wen = 3'b000;
        addr[2*AW +: AW] = AW'(5);
        tick();
        chk("read.gnt", 32'(gnt), 32'(3'b100));
        chk("read.rv_c1", 32'(rvalid), 0);
        tick();
        chk("read.ren_c2", 32'(ram_ren), 1);
        chk("read.addr_c2", 32'(ram_addr), 5);
        chk("read.rv_c2", 32'(rvalid), 0);
        addr[2*AW +: AW] = AW'(6);
        tick();
        chk("read.addr_c3", 32'(ram_addr), 6);
        chk("read.rv_c3", 32'(rvalid), 0);
        req = 3'b000;
        tick();
        chk("read.rv_c4", 32'(rvalid), 32'(3'b100));
        chk("read.rdata_c4", 32'(rdata), 15);
        tick();
        chk("read.rv_c5", 32'(rvalid), 32'(3'b100));
        chk("read.rdata_c5", 32'(rdata), 18);
        tick();
        chk("read.rv_c6", 32'(rvalid), 0);

        // reset one cycle after ram_ren: the read in flight never returns
        req = 3'b100;
        wen = 3'b000;
        addr[2*AW +: AW] = AW'(7);
        tick();
        tick();
        chk("rstrd.ren", 32'(ram_ren), 1);
        rst_n = 1'b0;
        req   = 3'b000;
        tick();
        chk_idle_zero("rstrd");
        chk("rstrd.ram_addr", 32'(ram_addr), 0);
        chk("rstrd.ram_wdata", 32'(ram_wdata), 0);
        rst_n = 1'b1;
        tick();
        chk("rstrd.rv_c4", 32'(rvalid), 0);
        tick();
        chk("rstrd.rv_c5", 32'(rvalid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
